rf_dump_scanner: RTL and testbench

Synthesizable end-of-run register-file dump engine attached to the pipelined RISC-V core's debug read port (`reg_sel` / `reg_data`).

- Watches the core's committed PC and a cycle budget.
- On a stop condition it halts the core, walks `reg_sel` through x0..x31, and streams a 34-beat dump over a valid/ready interface to a UART/trace sink.
- Replaces simulation-only stop-and-print checking with hardware usable on FPGA.

---
 rtl/rf_dump_scanner.sv | 125 ++++++++++++
 tb/tb_rf_dump_scanner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_scanner.sv
// End-of-run register-file dump engine: halts the core on a stop PC or cycle budget,
// then streams PC, cycle count and x0..x31 over a valid/ready interface.
module rf_dump_scanner #(
    parameter logic [31:0] STOP_PC    = 32'h0000_0048,
    parameter int unsigned MAX_CYCLES = 1000,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        cpu_halt,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic        dump_last,
    output logic        timeout,
    output logic        done
);

    typedef enum logic [1:0] {RUN, SEND, READ, DONE} state_e;

    localparam logic [31:0] MAX_C   = 32'(MAX_CYCLES);
    localparam logic [1:0]  RD_LAST = 2'(RD_LAT - 1);
    localparam logic [5:0]  IDX_END = 6'd33;

    state_e      state_q;
    logic [31:0] cyc_q;
    logic [5:0]  idx_q;
    logic [1:0]  wait_q;
    logic [4:0]  sel_q;
    logic [31:0] data_q;
    logic        valid_q;
    logic        last_q;
    logic        halt_q;
    logic        to_q;
    logic        done_q;

    logic        pc_trig;
    logic        bud_trig;
    logic [5:0]  idx_d;

    always_comb begin
        pc_trig  = (pc_in == STOP_PC);
        bud_trig = (cyc_q == MAX_C);
        idx_d    = idx_q + 6'd1;
    end

    // cyc_q stops counting once RUN is left, so it doubles as the latched count for beat 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cyc_q   <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            halt_q  <= 1'b0;
            to_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (pc_trig || bud_trig) begin
                        state_q <= SEND;
                        data_q  <= pc_in;
                        to_q    <= !pc_trig;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        halt_q  <= 1'b1;
                    end else if (cyc_q < MAX_C) begin
                        cyc_q <= cyc_q + 32'd1;
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        if (idx_q == IDX_END) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sel_q   <= 5'd31;
                        end else if (idx_d < 6'd2) begin
                            idx_q  <= idx_d;
                            data_q <= cyc_q;
                        end else begin
                            idx_q   <= idx_d;
                            sel_q   <= 5'(idx_d - 6'd2);
                            wait_q  <= '0;
                            valid_q <= 1'b0;
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (wait_q == RD_LAST) begin
                        data_q  <= reg_data;
                        valid_q <= 1'b1;
                        last_q  <= (idx_q == IDX_END);
                        state_q <= SEND;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                DONE: begin
                    sel_q <= 5'd31;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign cpu_halt   = halt_q;
    assign reg_sel    = sel_q;
    assign dump_valid = valid_q;
    assign dump_data  = data_q;
    assign dump_last  = last_q;
    assign timeout    = to_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rf_dump_scanner.sv
// Bench for rf_dump_scanner: two instances (RD_LAT 1 and 3) against a beat-stream model.
module tb_rf_dump_scanner;

    localparam logic [31:0] STOP = 32'h0000_0048;
    localparam int          MAXC = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [31:0] pc_in = '0;
    logic        dump_ready = 1'b1;
    logic [31:0] base = 32'h100;

    logic        a_halt, a_valid, a_last, a_to, a_done;
    logic [4:0]  a_sel;
    logic [31:0] a_rdata, a_data;
    logic        b_halt, b_valid, b_last, b_to, b_done;
    logic [4:0]  b_sel;
    logic [31:0] b_rdata, b_data;
    logic [31:0] b_p1, b_p2;

    rf_dump_scanner #(.STOP_PC(STOP), .MAX_CYCLES(MAXC), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .pc_in(pc_in), .cpu_halt(a_halt), .reg_sel(a_sel),
        .reg_data(a_rdata), .dump_valid(a_valid), .dump_ready(dump_ready),
        .dump_data(a_data), .dump_last(a_last), .timeout(a_to), .done(a_done));

    rf_dump_scanner #(.STOP_PC(STOP), .MAX_CYCLES(MAXC), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .pc_in(pc_in), .cpu_halt(b_halt), .reg_sel(b_sel),
        .reg_data(b_rdata), .dump_valid(b_valid), .dump_ready(dump_ready),
        .dump_data(b_data), .dump_last(b_last), .timeout(b_to), .done(b_done));

    // Debug ports: immediate for latency 1, two register stages for latency 3.
    assign a_rdata = base + 32'(a_sel);
    always @(posedge clk) begin
        b_p1 <= base + 32'(b_sel);
        b_p2 <= b_p1;
    end
    assign b_rdata = b_p2;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    // Run-phase model: cycle count and trigger edge.
    bit          m_run = 1'b1;
    int          m_cyc = 0;
    int          trig_e = 0;
    logic [31:0] e_pc = '0, e_cyc = '0;
    logic        e_to = 1'b0;

    int mode = 0;
    bit bp = 1'b0;
    int zrun = 0;

    int          bn [2];
    bit          hold [2];
    logic [31:0] hold_d [2];
    bit          seen [2];
    int          done_e [2];
    logic [31:0] rec [2][34];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h (edge %0d)", name, got, exp, ecnt);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        chk(name, {31'b0, got}, {31'b0, exp});
    endtask

    function automatic logic [31:0] exp_beat(input int k);
        if (k == 0) return e_pc;
        if (k == 1) return e_cyc;
        return base + 32'(k - 2);
    endfunction

    // Edges after the trigger at which beat k first appears with the sink always ready.
    function automatic int beat_off(input int k, input int lat);
        if (k == 0) return 0;
        return 1 + (k - 1) * (lat + 1);
    endfunction

    function automatic logic [31:0] pc_for(input int n);
        case (mode)
            0:       return 32'(4 * n);
            1:       return 32'h1000 + 32'(4 * n);
            default: return (n == MAXC) ? STOP : 32'h2000;
        endcase
    endfunction

    always @(posedge clk) begin
        ecnt++;
        if (rst) begin
            m_run = 1'b1;
            m_cyc = 0;
        end else if (m_run) begin
            if (pc_in == STOP || m_cyc == MAXC) begin
                m_run  = 1'b0;
                trig_e = ecnt;
                e_pc   = pc_in;
                e_cyc  = 32'(m_cyc);
                e_to   = (pc_in != STOP);
            end else begin
                m_cyc++;
            end
        end
    end

    task automatic check_inst(input int i, input int lat, input logic halt, input logic valid,
                              input logic last, input logic to, input logic dn,
                              input logic [4:0] sel, input logic [31:0] data);
        string p;
        p = (i == 0) ? "A" : "B";
        if (m_run) begin
            chk1({p, " run halt"}, halt, 1'b0);
            chk1({p, " run valid"}, valid, 1'b0);
            chk1({p, " run last"}, last, 1'b0);
            chk1({p, " run timeout"}, to, 1'b0);
            chk1({p, " run done"}, dn, 1'b0);
            chk({p, " run reg_sel"}, {27'b0, sel}, 32'h0);
            chk({p, " run data"}, data, 32'h0);
        end else begin
            chk1({p, " halt"}, halt, 1'b1);
            chk1({p, " timeout"}, to, e_to);
            if (bn[i] < 34) begin
                chk1({p, " early done"}, dn, 1'b0);
                if (hold[i]) begin
                    chk1({p, " hold valid"}, valid, 1'b1);
                    chk({p, " hold data"}, data, hold_d[i]);
                end
                hold[i] = 1'b0;
                if (valid) begin
                    chk($sformatf("%s beat%0d data", p, bn[i]), data, exp_beat(bn[i]));
                    chk1($sformatf("%s beat%0d last", p, bn[i]), last, bn[i] == 33);
                    if (!seen[i]) begin
                        seen[i] = 1'b1;
                        if (!bp)
                            chk($sformatf("%s beat%0d latency", p, bn[i]),
                                32'(ecnt - trig_e), 32'(beat_off(bn[i], lat)));
                    end
                    rec[i][bn[i]] = data;
                    if (dump_ready) begin
                        bn[i]++;
                        seen[i] = 1'b0;
                    end else begin
                        hold[i]   = 1'b1;
                        hold_d[i] = data;
                    end
                end
            end else begin
                chk1({p, " done"}, dn, 1'b1);
                chk1({p, " done valid"}, valid, 1'b0);
                chk1({p, " done last"}, last, 1'b0);
                chk({p, " done reg_sel"}, {27'b0, sel}, 32'd31);
                if (done_e[i] < 0) done_e[i] = ecnt;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                bn[i] = 0; hold[i] = 1'b0; seen[i] = 1'b0; done_e[i] = -1;
            end
        end else begin
            check_inst(0, 1, a_halt, a_valid, a_last, a_to, a_done, a_sel, a_data);
            check_inst(1, 3, b_halt, b_valid, b_last, b_to, b_done, b_sel, b_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pc_in = pc_for(m_cyc);
        if (bp) begin
            if (zrun >= 5) dump_ready = 1'b1;
            else dump_ready = 1'($urandom_range(0, 1));
            zrun = dump_ready ? 0 : zrun + 1;
        end else begin
            dump_ready = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!(done_e[0] >= 0 && done_e[1] >= 0) && n < limit) begin
            tick();
            n++;
        end
        chk1({name, " dump completed"}, done_e[0] >= 0 && done_e[1] >= 0, 1'b1);
        repeat (4) tick();
    endtask

    initial begin
        int n;
        // PC trigger, sink always ready.
        mode = 0; bp = 1'b0; base = 32'h100;
        do_reset();
        wait_done("pc", 400);
        chk("pc beat0", rec[0][0], 32'h48);
        chk("pc beat1", rec[0][1], 32'h12);
        chk("pc x0", rec[0][2], 32'h100);
        chk("pc x31", rec[0][33], 32'h11F);
        chk("pc lat3 x31", rec[1][33], 32'h11F);
        chk("pc done edge A", 32'(done_e[0] - trig_e), 32'd66);
        chk("pc done edge B", 32'(done_e[1] - trig_e), 32'd130);
        chk1("pc timeout", a_to, 1'b0);

        // Cycle budget trigger.
        mode = 1;
        do_reset();
        wait_done("budget", 1300);
        chk("budget beat0", rec[0][0], 32'h1FA0);
        chk("budget beat1", rec[0][1], 32'h3E8);
        chk1("budget timeout", a_to, 1'b1);

        // Both triggers on the same edge.
        mode = 2;
        do_reset();
        wait_done("both", 1300);
        chk("both beat0", rec[0][0], 32'h48);
        chk("both beat1", rec[1][1], 32'h3E8);
        chk1("both timeout", b_to, 1'b0);

        // Random backpressure.
        mode = 0; bp = 1'b1; zrun = 0;
        do_reset();
        wait_done("bp", 2500);
        chk("bp beat count", 32'(bn[0]), 32'd34);
        chk("bp beat1", rec[0][1], 32'h12);
        chk("bp x31", rec[1][33], 32'h11F);
        bp = 1'b0;

        // Reset while beat x10 is on the bus, then a fresh dump.
        do_reset();
        n = 0;
        while (!(bn[0] == 12 && a_valid) && n < 200) begin
            tick();
            n++;
        end
        chk1("x10 reached", bn[0] == 12 && a_valid, 1'b1);
        rst = 1'b1;
        base = 32'h200;
        tick();
        rst = 1'b0;
        chk1("mid rst valid", a_valid, 1'b0);
        chk1("mid rst halt", a_halt, 1'b0);
        chk("mid rst data", a_data, 32'h0);
        wait_done("fresh", 400);
        chk("fresh beat1", rec[0][1], 32'h12);
        chk("fresh x0", rec[0][2], 32'h200);
        chk("fresh x31", rec[1][33], 32'h21F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
